// File: rtl/alu_host_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// alu_host_sequencer_pkg
//   Shared definitions for the arithmetic-unit host sequencer: opcode
//   constants, default datapath width, sequencer state type and a small
//   helper that tells single-word from two-word result operations.
// ---------------------------------------------------------------------------
package alu_host_sequencer_pkg;

    localparam int unsigned W_DEFAULT = 64;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_LOAD_Y,
        ST_LOAD_X,
        ST_WAIT,
        ST_RESP
    } seq_state_e;

    // mul/div return two words (hi/remainder then lo/quotient);
    // add/sub return a single word.
    function automatic logic is_two_word(input logic [1:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_seq_timer.sv
// ---------------------------------------------------------------------------
// alu_seq_timer
//   Watchdog counter for the sequencer WAIT state. Counts up from zero
//   while enabled and stops (saturates) at TIMEOUT_CYCLES-1, where it
//   asserts expired. clear has priority over enable.
//
// Ports
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset
//   clear    in   return count to zero
//   enable   in   advance count by one (unless already expired)
//   expired  out  count == TIMEOUT_CYCLES-1
// ---------------------------------------------------------------------------
module alu_seq_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 512
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + CW'(1);
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/alu_host_sequencer.sv
// ---------------------------------------------------------------------------
// alu_host_sequencer
//   Bus-side initiator for the arithmetic unit. Takes one operation per
//   valid/ready request, pulses alu_bgn, presents operand y then x on
//   alu_inbus, waits for alu_stop and captures the result word(s) from
//   alu_outbus, then offers them on a valid/ready response port. A WAIT
//   watchdog aborts with rsp_err=1 if stop never arrives.
//
// Ports
//   clk, rst               clock / synchronous active-high reset
//   req_valid/req_ready    request handshake (ready only in IDLE)
//   req_opcode             00 add, 01 sub, 10 mul, 11 div
//   req_x, req_y           first / second operand
//   rsp_valid/rsp_ready    response handshake (valid held until ready)
//   rsp_hi, rsp_lo         result words (hi=0 for add/sub)
//   rsp_err                timeout abort, data forced to zero
//   alu_bgn                one-cycle start pulse to the arithmetic unit
//   alu_opcode             opcode, stable through the operation
//   alu_inbus              operand bus, zero outside the two load cycles
//   alu_stop               arithmetic unit done
//   alu_outbus             result bus from the arithmetic unit
// ---------------------------------------------------------------------------
module alu_host_sequencer
    import alu_host_sequencer_pkg::*;
#(
    parameter int unsigned W              = W_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 512
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [1:0]   req_opcode,
    input  logic [W-1:0] req_x,
    input  logic [W-1:0] req_y,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_hi,
    output logic [W-1:0] rsp_lo,
    output logic         rsp_err,
    output logic         alu_bgn,
    output logic [1:0]   alu_opcode,
    output logic [W-1:0] alu_inbus,
    input  logic         alu_stop,
    input  logic [W-1:0] alu_outbus
);

    seq_state_e state, state_nxt;

    logic [1:0]   op_r;
    logic [W-1:0] x_r;
    logic [W-1:0] y_r;
    logic [W-1:0] prev_out;
    logic [W-1:0] hi_r;
    logic [W-1:0] lo_r;
    logic         err_r;

    logic accept;
    logic capture_stop;
    logic capture_timeout;
    logic timer_expired;

    alu_seq_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (state != ST_WAIT),
        .enable (state == ST_WAIT),
        .expired(timer_expired)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and state-decoded outputs
    always_comb begin
        state_nxt       = state;
        req_ready       = 1'b0;
        rsp_valid       = 1'b0;
        alu_bgn         = 1'b0;
        alu_inbus       = '0;
        accept          = 1'b0;
        capture_stop    = 1'b0;
        capture_timeout = 1'b0;

        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept    = 1'b1;
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                alu_bgn   = 1'b1;
                state_nxt = ST_LOAD_Y;
            end
            ST_LOAD_Y: begin
                alu_inbus = y_r;
                state_nxt = ST_LOAD_X;
            end
            ST_LOAD_X: begin
                alu_inbus = x_r;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                // stop takes priority over a coincident timeout
                if (alu_stop) begin
                    capture_stop = 1'b1;
                    state_nxt    = ST_RESP;
                end else if (timer_expired) begin
                    capture_timeout = 1'b1;
                    state_nxt       = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Request latch, outbus history and result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            op_r     <= '0;
            x_r      <= '0;
            y_r      <= '0;
            prev_out <= '0;
            hi_r     <= '0;
            lo_r     <= '0;
            err_r    <= 1'b0;
        end else begin
            if (accept) begin
                op_r <= req_opcode;
                x_r  <= req_x;
                y_r  <= req_y;
            end

            // The unit presents the first result word one cycle before
            // stop rises, so keep the previous cycle's bus value around.
            if (state == ST_WAIT) begin
                prev_out <= alu_outbus;
            end

            if (capture_stop) begin
                if (is_two_word(op_r)) begin
                    hi_r <= prev_out;
                    lo_r <= alu_outbus;
                end else begin
                    hi_r <= '0;
                    lo_r <= prev_out;
                end
                err_r <= 1'b0;
            end else if (capture_timeout) begin
                hi_r  <= '0;
                lo_r  <= '0;
                err_r <= 1'b1;
            end
        end
    end

    assign alu_opcode = op_r;
    assign rsp_hi     = hi_r;
    assign rsp_lo     = lo_r;
    assign rsp_err    = err_r;

endmodule

// File: tb/tb_alu_host_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_host_sequencer
//   Drives directed operations through alu_host_sequencer against a
//   behavioural arithmetic unit, checks every cycle against a
//   transaction-level expectation and pins key results to literals.
// ---------------------------------------------------------------------------
module tb_alu_host_sequencer;

    localparam int unsigned W  = 64;
    localparam int unsigned TO = 512;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [1:0]   req_opcode;
    logic [W-1:0] req_x;
    logic [W-1:0] req_y;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_hi;
    logic [W-1:0] rsp_lo;
    logic         rsp_err;
    logic         alu_bgn;
    logic [1:0]   alu_opcode;
    logic [W-1:0] alu_inbus;
    logic         alu_stop;
    logic [W-1:0] alu_outbus;

    int n_checks = 0;
    int n_fail   = 0;
    int alu_lat  = 3;
    bit never_stop = 1'b0;

    always #5 clk = ~clk;

    alu_host_sequencer #(
        .W(W),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_opcode(req_opcode),
        .req_x     (req_x),
        .req_y     (req_y),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_hi    (rsp_hi),
        .rsp_lo    (rsp_lo),
        .rsp_err   (rsp_err),
        .alu_bgn   (alu_bgn),
        .alu_opcode(alu_opcode),
        .alu_inbus (alu_inbus),
        .alu_stop  (alu_stop),
        .alu_outbus(alu_outbus)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Behavioural arithmetic unit: samples on the falling edge, drives the
    // next cycle's stop/outbus just after the rising edge.
    initial begin : alu_model
        int phase = 0;
        int w = 0;
        logic [1:0]   m_op;
        logic [63:0]  m_x, m_y, r_hi, r_lo;
        logic [127:0] p;
        bit           two;
        logic         nstop;
        logic [63:0]  nout;
        alu_stop   = 1'b0;
        alu_outbus = '0;
        forever begin
            @(negedge clk);
            nstop = 1'b0;
            nout  = {$urandom, $urandom};
            if (rst) begin
                phase = 0;
            end else begin
                case (phase)
                    0: if (alu_bgn === 1'b1) begin
                        m_op  = alu_opcode;
                        phase = 1;
                    end
                    1: begin
                        m_y   = alu_inbus;
                        phase = 2;
                    end
                    2: begin
                        m_x = alu_inbus;
                        two = m_op[1];
                        case (m_op)
                            2'b00: begin r_hi = '0; r_lo = m_x + m_y; end
                            2'b01: begin r_hi = '0; r_lo = m_x - m_y; end
                            2'b10: begin
                                p    = {64'd0, m_x} * {64'd0, m_y};
                                r_hi = p[127:64];
                                r_lo = p[63:0];
                            end
                            default: begin
                                r_hi = (m_y != 0) ? m_x % m_y : '1;
                                r_lo = (m_y != 0) ? m_x / m_y : '1;
                            end
                        endcase
                        w     = -1;
                        phase = never_stop ? 0 : 3;
                    end
                    default: ;
                endcase
                if (phase == 3) begin
                    w++;
                    nstop = (w == alu_lat) || (w == alu_lat + 1);
                    if (w == alu_lat - 1) nout = two ? r_hi : r_lo;
                    else if (w == alu_lat && two) nout = r_lo;
                    if (w == alu_lat + 1) phase = 0;
                end
            end
            @(posedge clk);
            #1;
            alu_stop   = nstop;
            alu_outbus = nout;
        end
    end

    // Transaction-level expectation, checked every cycle.
    initial begin : scoreboard
        bit armed = 1'b0;
        bit fl = 1'b0;
        bit fl_pre, ev;
        int c = 0, acc = 0, done = -1;
        logic [1:0]   s_op;
        logic [63:0]  s_x, s_y, e_hi, e_lo, ein;
        logic         e_err;
        logic [127:0] p;
        forever begin
            @(negedge clk);
            c++;
            ev = fl && done >= 0 && c >= done;
            if (armed) begin
                chk("req_ready", req_ready, !fl);
                chk("alu_bgn", alu_bgn, fl && c == acc + 1);
                ein = '0;
                if (fl && c == acc + 2) ein = s_y;
                else if (fl && c == acc + 3) ein = s_x;
                chk("alu_inbus", alu_inbus, ein);
                chk("rsp_valid", rsp_valid, ev);
                if (ev) begin
                    chk("rsp_hi", rsp_hi, e_hi);
                    chk("rsp_lo", rsp_lo, e_lo);
                    chk("rsp_err", rsp_err, e_err);
                end
                if (fl && c > acc && (done < 0 || c < done))
                    chk("alu_opcode", alu_opcode, s_op);
            end
            fl_pre = fl;
            if (rst) begin
                fl    = 1'b0;
                done  = -1;
                armed = 1'b1;
            end else begin
                if (fl && done < 0 && c >= acc + 4) begin
                    if (alu_stop) begin
                        done  = c + 1;
                        e_err = 1'b0;
                        case (s_op)
                            2'b00: begin e_hi = '0; e_lo = s_x + s_y; end
                            2'b01: begin e_hi = '0; e_lo = s_x - s_y; end
                            2'b10: begin
                                p    = {64'd0, s_x} * {64'd0, s_y};
                                e_hi = p[127:64];
                                e_lo = p[63:0];
                            end
                            default: begin e_hi = s_x % s_y; e_lo = s_x / s_y; end
                        endcase
                    end else if (c == acc + 4 + TO - 1) begin
                        done  = c + 1;
                        e_err = 1'b1;
                        e_hi  = '0;
                        e_lo  = '0;
                    end
                end
                if (ev && rsp_ready) fl = 1'b0;
                if (!fl_pre && req_valid) begin
                    fl   = 1'b1;
                    acc  = c;
                    done = -1;
                    s_op = req_opcode;
                    s_x  = req_x;
                    s_y  = req_y;
                end
            end
        end
    end

    task automatic do_op(input logic [1:0] op, input logic [63:0] x, input logic [63:0] y,
                         input int lat, input int hold, input bit nostop, input int rst_at,
                         output logic [63:0] hi, output logic [63:0] lo, output logic er,
                         output int latency);
        int n;
        hi = 'x;
        lo = 'x;
        er = 1'bx;
        latency = 0;
        alu_lat = lat;
        never_stop = nostop;
        @(posedge clk);
        #1;
        req_valid  = 1'b1;
        req_opcode = op;
        req_x      = x;
        req_y      = y;
        rsp_ready  = (hold == 0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (req_ready !== 1'b1 && n < 50);
        chk("accept", req_ready, 1);
        if (req_ready !== 1'b1) begin
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        // keep a different request pending while busy: must not be taken
        req_opcode = ~op;
        req_x      = ~x;
        req_y      = ~y;
        while (1) begin
            @(negedge clk);
            latency++;
            if (rsp_valid === 1'b1 || latency >= TO + 40) break;
            @(posedge clk);
            #1;
            if (latency == 3) req_valid = 1'b0;
            if (rst_at != 0 && latency == rst_at) begin
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
                @(negedge clk);
                chk("rst_req_ready", req_ready, 1);
                chk("rst_rsp_valid", rsp_valid, 0);
                chk("rst_inbus", alu_inbus, 0);
                chk("rst_bgn", alu_bgn, 0);
                return;
            end
        end
        chk("rsp_arrives", rsp_valid, 1);
        if (rsp_valid !== 1'b1) begin
            rsp_ready = 1'b1;
            return;
        end
        for (int h = 1; h < hold; h++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            chk("hold_req_ready", req_ready, 0);
            chk("hold_rsp_valid", rsp_valid, 1);
        end
        if (hold > 0) begin
            @(posedge clk);
            #1;
            rsp_ready = 1'b1;
            @(negedge clk);
        end
        hi = rsp_hi;
        lo = rsp_lo;
        er = rsp_err;
        @(posedge clk);
        #1;
    endtask

    initial begin : stimulus
        logic [63:0] hi, lo;
        logic        er;
        int          lt;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_opcode = '0;
        req_x      = '0;
        req_y      = '0;
        rsp_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_req_ready", req_ready, 1);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_hi", rsp_hi, 0);
        chk("reset_rsp_lo", rsp_lo, 0);
        chk("reset_rsp_err", rsp_err, 0);
        chk("reset_bgn", alu_bgn, 0);
        chk("reset_opcode", alu_opcode, 0);
        chk("reset_inbus", alu_inbus, 0);

        do_op(2'b00, 64'd5, 64'd3, 3, 0, 0, 0, hi, lo, er, lt);
        chk("add_lo", lo, 64'd8);
        chk("add_hi", hi, 64'd0);
        chk("add_err", er, 0);
        chk("add_latency", lt, 8);

        do_op(2'b01, 64'd3, 64'd5, 1, 0, 0, 0, hi, lo, er, lt);
        chk("sub_lo", lo, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("sub_hi", hi, 64'd0);

        do_op(2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 6, 0, 0, 0, hi, lo, er, lt);
        chk("mul_hi", hi, 64'd1);
        chk("mul_lo", lo, 64'hFFFF_FFFF_FFFF_FFFE);

        do_op(2'b11, 64'd100, 64'd7, 4, 5, 0, 0, hi, lo, er, lt);
        chk("div_rem", hi, 64'd2);
        chk("div_quo", lo, 64'd14);
        chk("div_err", er, 0);

        do_op(2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 2, 0, 0, 0, hi, lo, er, lt);
        chk("add_wrap_lo", lo, 64'd0);

        do_op(2'b10, 64'h1_0000_0000, 64'h1_0000_0000, 2, 0, 0, 0, hi, lo, er, lt);
        chk("mul32_hi", hi, 64'd1);
        chk("mul32_lo", lo, 64'd0);

        do_op(2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'd16, 1, 2, 0, 0, hi, lo, er, lt);
        chk("div16_rem", hi, 64'd15);
        chk("div16_quo", lo, 64'h0FFF_FFFF_FFFF_FFFF);

        do_op(2'b00, 64'd7, 64'd8, 3, 0, 1, 0, hi, lo, er, lt);
        chk("timeout_err", er, 1);
        chk("timeout_hi", hi, 64'd0);
        chk("timeout_lo", lo, 64'd0);
        chk("timeout_latency", lt, 4 + TO);

        do_op(2'b00, 64'd9, 64'd9, 1, 0, 0, 0, hi, lo, er, lt);
        chk("recover_lo", lo, 64'd18);
        chk("recover_err", er, 0);

        do_op(2'b10, 64'd3, 64'd4, 50, 0, 0, 8, hi, lo, er, lt);

        do_op(2'b00, 64'd1, 64'd1, 2, 0, 0, 0, hi, lo, er, lt);
        chk("post_rst_lo", lo, 64'd2);
        chk("post_rst_hi", hi, 64'd0);
        chk("post_rst_err", er, 0);

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
